pattern_tx: RTL

PATTERN_TX -- requirements
Module: pattern_tx

---
 rtl/pattern_tx.sv | 125 ++++++++++++
 1 files changed

// File: rtl/pattern_tx.sv
// pattern_tx: serialises a latched 4-bit pattern MSB first, repeated for a
// number of frames with GAP idle cycles between them. PATTERN_TX_PARITY_EN adds an even-parity bit per frame.
module pattern_tx #(
  parameter int GAP = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] pattern,
  input  logic [3:0] count,
  output logic       out,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND,
    S_GAP,
    S_DONE
`ifdef PATTERN_TX_PARITY_EN
    , S_PAR
`endif
  } state_t;

  localparam logic [2:0] GAP_LAST = (GAP == 0) ? 3'd0 : 3'(GAP - 1);

  state_t     state_q, state_d, frame_next;
  logic [3:0] pat_q;
  logic [3:0] remaining_q;
  logic [1:0] idx_q;
  logic [2:0] gap_cnt_q;

  // NOTE: state and datapath registers use non-blocking assignments so every
  // flop samples values from before the edge, independent of block ordering.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Where a frame goes once its last bit (data or parity) has been sent.
  always_comb begin
    if (remaining_q != 4'd1) frame_next = (GAP > 0) ? S_GAP : S_SEND;
    else                     frame_next = S_DONE;
  end

  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start) state_d = (count != 4'd0) ? S_SEND : S_DONE;
      S_SEND: begin
        if (idx_q == 2'd0) begin
`ifdef PATTERN_TX_PARITY_EN
          state_d = S_PAR;
`else
          state_d = frame_next;
`endif
        end
      end
`ifdef PATTERN_TX_PARITY_EN
      S_PAR:  state_d = frame_next;
`endif
      S_GAP:  if (gap_cnt_q == GAP_LAST) state_d = S_SEND;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // The bit index wraps 0 -> 3, so every new frame starts at the MSB.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pat_q       <= 4'd0;
      remaining_q <= 4'd0;
      idx_q       <= 2'd0;
      gap_cnt_q   <= 3'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start && count != 4'd0) begin
            pat_q       <= pattern;
            remaining_q <= count;
            idx_q       <= 2'd3;
            gap_cnt_q   <= 3'd0;
          end
        end
        S_SEND: begin
          idx_q     <= idx_q - 2'd1;
          gap_cnt_q <= 3'd0;
`ifndef PATTERN_TX_PARITY_EN
          if (idx_q == 2'd0) remaining_q <= remaining_q - 4'd1;
`endif
        end
`ifdef PATTERN_TX_PARITY_EN
        S_PAR:  remaining_q <= remaining_q - 4'd1;
`endif
        S_GAP:  gap_cnt_q <= gap_cnt_q + 3'd1;
        default: ;
      endcase
    end
  end

  always_comb begin
    out  = 1'b0;
    busy = 1'b0;
    done = 1'b0;
    case (state_q)
      S_SEND: begin
        out  = pat_q[idx_q];
        busy = 1'b1;
      end
`ifdef PATTERN_TX_PARITY_EN
      S_PAR: begin
        out  = ^pat_q;
        busy = 1'b1;
      end
`endif
      S_GAP:  busy = 1'b1;
      S_DONE: done = 1'b1;
      default: ;
    endcase
  end

endmodule
